seq_divider_64by32: RTL and testbench

//  Iterative radix-2 restoring divider. It is the inverse of the 32x32 vedic multiplier path.
//  It takes a 64-bit dividend (typically a full product) and a 32-bit divisor (typically modulus q).
//  It returns the 64-bit quotient and the 32-bit remainder, so NTT butterflies can reduce products mod q.

---
 rtl/ntt_pkg.sv | 13 +
 rtl/div_cond_sub.sv | 20 ++
 rtl/seq_divider_64by32.sv | 117 +++++++++++
 tb/tb_seq_divider_64by32.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT arithmetic path: datapath widths and divider state encoding.
package ntt_pkg;

    localparam int unsigned NTT_W      = 32;
    localparam int unsigned NTT_PROD_W = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_cond_sub.sv
// One restoring-division step: compare the shifted partial remainder against the divisor and
// subtract when it fits, producing the next partial remainder and one quotient bit.
module div_cond_sub #(
    parameter int unsigned DIVISOR_W = 32
) (
    input  logic [DIVISOR_W:0]   pr_shifted,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] pr_next,
    output logic                 qbit
);

    logic [DIVISOR_W:0] diff;

    // pr_shifted < 2*divisor always holds, so the MSB of this single subtraction is the borrow
    // and a successful subtraction always leaves a result that fits in DIVISOR_W bits.
    assign diff    = pr_shifted - {1'b0, divisor};
    assign qbit    = ~diff[DIVISOR_W];
    assign pr_next = diff[DIVISOR_W] ? pr_shifted[DIVISOR_W-1:0] : diff[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_divider_64by32.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Produces floor(dividend/divisor) and dividend mod divisor; divide-by-zero is flagged.
module seq_divider_64by32
    import ntt_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = NTT_PROD_W,
    parameter int unsigned DIVISOR_W  = NTT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_W);

    div_state_e            state_q, state_d;
    logic [DIVIDEND_W-1:0] dq_q, dq_d;
    logic [DIVISOR_W-1:0]  pr_q, pr_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    pr_shifted;
    logic [DIVISOR_W-1:0]  pr_next;
    logic                  qbit;

    // The stored remainder is always below the divisor, so its extra top bit is implicitly zero.
    assign pr_shifted = {pr_q, dq_q[DIVIDEND_W-1]};

    div_cond_sub #(
        .DIVISOR_W (DIVISOR_W)
    ) u_cond_sub (
        .pr_shifted (pr_shifted),
        .divisor    (divisor_q),
        .pr_next    (pr_next),
        .qbit       (qbit)
    );

    always_comb begin
        state_d   = state_q;
        dq_d      = dq_q;
        pr_d      = pr_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    divisor_d = divisor;
                    if (divisor != '0) begin
                        dq_d    = dividend;
                        pr_d    = '0;
                        cnt_d   = CNT_W'(DIVIDEND_W - 1);
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        dq_d    = '1;
                        pr_d    = dividend[DIVISOR_W-1:0];
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                pr_d  = pr_next;
                dq_d  = {dq_q[DIVIDEND_W-2:0], qbit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    dbz_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dq_q      <= '0;
            pr_q      <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dq_q      <= dq_d;
            pr_q      <= pr_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            dbz_q     <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = dq_q;
    assign remainder   = pr_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_64by32.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, and randomized
// operations with output stalls checked against a / and % reference.
module tb_seq_divider_64by32;

    localparam int unsigned DW = 64;
    localparam int unsigned VW = 32;
    localparam int unsigned N_RAND = 600;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_divider_64by32 #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (VW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one operation and returns just after the accept edge.
    task automatic start_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_op(input int stall, output logic [DW-1:0] q, output logic [VW-1:0] r,
                             output logic z);
        out_ready = 1'b0;
        repeat (stall) tick();
        q = quotient;
        r = remainder;
        z = div_by_zero;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] q, a, q_exp;
        logic [VW-1:0] r, b, r_exp;
        logic          z;
        int            lat;
        logic [DW-1:0] snap_q;
        logic [VW-1:0] snap_r;
        logic          snap_z;

        vecs[0] = '{64'd100, 32'd7, 64'd14, 32'd2, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0001_0000_0001, 32'd0, 1'b0};
        vecs[2] = '{64'd5, 32'd9, 64'd0, 32'd5, 1'b0};
        vecs[3] = '{64'hDEAD_BEEF_0123_4567, 32'd1, 64'hDEAD_BEEF_0123_4567, 32'd0, 1'b0};
        vecs[4] = '{64'h1234, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1234, 1'b1};
        vecs[5] = '{64'd1000, 32'd33, 64'd30, 32'd10, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'd2, 64'h7FFF_FFFF_FFFF_FFFF, 32'd1, 1'b0};
        vecs[7] = '{64'h1_0000_0000, 32'h8000_0000, 64'd2, 32'd0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        rst = 1'b0;

        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_quotient", quotient, 64'd0);
        check("reset_remainder", {32'd0, remainder}, 64'd0);
        check("reset_div_by_zero", {63'd0, div_by_zero}, 64'd0);

        // Directed table: result values plus latency from the accept edge.
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), vecs[i].z ? 64'd0 : 64'd64);
            finish_op(0, q, r, z);
            check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), {32'd0, r}, {32'd0, vecs[i].r});
            check($sformatf("vec%0d_div_by_zero", i), {63'd0, z}, {63'd0, vecs[i].z});
            check($sformatf("vec%0d_dbz_cleared", i), {63'd0, div_by_zero}, 64'd0);
            check($sformatf("vec%0d_ready_after", i), {63'd0, in_ready}, 64'd1);
        end

        // Backpressure: result held for 10 cycles while in_valid pulses with other operands.
        start_op(64'd100, 32'd7);
        wait_done(lat);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        snap_q = quotient;
        snap_r = remainder;
        snap_z = div_by_zero;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            dividend = {$urandom, $urandom};
            divisor  = (c % 3 == 0) ? 32'd0 : $urandom;
            tick();
            check("bp_stable", {quotient[31:0], remainder}, {snap_q[31:0], snap_r});
            check("bp_stable_hi", {quotient[63:32], 30'd0, div_by_zero, out_valid},
                  {snap_q[63:32], 30'd0, snap_z, 1'b1});
            check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        check("bp_result_q", snap_q, 64'd14);
        check("bp_result_r", {32'd0, snap_r}, 64'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_in_ready_after", {63'd0, in_ready}, 64'd1);
        check("bp_out_valid_after", {63'd0, out_valid}, 64'd0);

        // Reset in the middle of an operation discards it.
        start_op(64'd100, 32'd7);
        repeat (30) tick();
        check("midrun_busy", {62'd0, in_ready, out_valid}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrun_reset_in_ready", {63'd0, in_ready}, 64'd1);
        start_op(64'd1000, 32'd33);
        wait_done(lat);
        check("after_reset_latency", 64'(lat), 64'd64);
        finish_op(2, q, r, z);
        check("after_reset_quotient", q, 64'd30);
        check("after_reset_remainder", {32'd0, r}, 64'd10);

        // Randomized operations against a plain-arithmetic reference.
        for (int n = 0; n < N_RAND; n++) begin
            int sel;
            sel = $urandom_range(0, 15);
            if (sel == 0) b = 32'd0;
            else if (sel < 5) b = 32'($urandom_range(1, 255));
            else b = $urandom;
            sel = $urandom_range(0, 3);
            a = (sel == 0) ? {32'd0, $urandom} : {$urandom, $urandom};
            if (b == 32'd0) begin
                q_exp = '1;
                r_exp = a[31:0];
            end else begin
                q_exp = a / {32'd0, b};
                r_exp = 32'(a % {32'd0, b});
            end
            start_op(a, b);
            wait_done(lat);
            check("rand_out_valid", {63'd0, out_valid}, 64'd1);
            finish_op($urandom_range(0, 3), q, r, z);
            check("rand_quotient", q, q_exp);
            check("rand_remainder", {32'd0, r}, {32'd0, r_exp});
            check("rand_div_by_zero", {63'd0, z}, {63'd0, (b == 32'd0)});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
